// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT_H = 2'd1,
    ST_EDIT_M = 2'd2,
    ST_EDIT_S = 2'd3
  } state_t;

  localparam logic [3:0] ENABLE_RUN = 4'b0001;
  localparam logic [3:0] ENABLE_SET = 4'b0100;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  localparam logic [2:0] FIELD_NONE   = 3'b000;
  localparam logic [2:0] FIELD_HOUR   = 3'b100;
  localparam logic [2:0] FIELD_MINUTE = 3'b010;
  localparam logic [2:0] FIELD_SECOND = 3'b001;

  // One-hot field indication for the display driver, derived from the state.
  function automatic logic [2:0] field_of(input state_t st);
    case (st)
      ST_EDIT_H: field_of = FIELD_HOUR;
      ST_EDIT_M: field_of = FIELD_MINUTE;
      ST_EDIT_S: field_of = FIELD_SECOND;
      default:   field_of = FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Combinational BCD +1/-1 on a {tens, ones} field that wraps between 00 and max.
module bcd_field_step (
  input  logic [7:0] value,
  input  logic [7:0] max,
  input  logic       up,
  input  logic       down,
  output logic [7:0] next
);

  // Up wins only when down is absent (and vice versa); both or neither leave the value alone.
  always_comb begin
    next = value;
    if (up && !down) begin
      if (value >= max)
        next = 8'h00;
      else if (value[3:0] == 4'd9)
        next = {value[7:4] + 4'd1, 4'd0};
      else
        next = {value[7:4], value[3:0] + 4'd1};
    end else if (down && !up) begin
      if (value == 8'h00)
        next = max;
      else if (value[3:0] == 4'd0)
        next = {value[7:4] - 4'd1, 4'd9};
      else
        next = {value[7:4], value[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode controller for the time-of-day counter: field selection, BCD editing,
// idle timeout back to run, and blink for the selected field.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT   = 30,
  parameter int BLINK_DIV = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] h,
  input  logic [7:0] m,
  input  logic [7:0] s,
  output logic [3:0] enable,
  output logic [7:0] set_hour,
  output logic [7:0] set_minute,
  output logic [7:0] set_second,
  output logic [2:0] field,
  output logic       blink
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   idle_cnt;
  logic [BW-1:0]   blink_cnt;
  logic [7:0]      hour_step;
  logic [7:0]      minute_step;
  logic [7:0]      second_step;
  logic            any_btn;
  logic            timeout_hit;

  assign any_btn = btn_mode | btn_up | btn_down;

  // Leaving on the edge where the idle count would reach TIMEOUT makes RUN visible
  // exactly TIMEOUT edges after the last button pulse.
  assign timeout_hit = (state != ST_RUN) && !any_btn && (idle_cnt >= IW'(TIMEOUT - 1));

  bcd_field_step u_hour_step (
    .value (set_hour),
    .max   (HOUR_MAX),
    .up    (btn_up),
    .down  (btn_down),
    .next  (hour_step)
  );

  bcd_field_step u_minute_step (
    .value (set_minute),
    .max   (MINSEC_MAX),
    .up    (btn_up),
    .down  (btn_down),
    .next  (minute_step)
  );

  bcd_field_step u_second_step (
    .value (set_second),
    .max   (MINSEC_MAX),
    .up    (btn_up),
    .down  (btn_down),
    .next  (second_step)
  );

  // Next state: btn_mode advances the field ring, otherwise idle timeout returns to RUN.
  always_comb begin
    state_next = state;
    if (btn_mode) begin
      case (state)
        ST_RUN:    state_next = ST_EDIT_H;
        ST_EDIT_H: state_next = ST_EDIT_M;
        ST_EDIT_M: state_next = ST_EDIT_S;
        ST_EDIT_S: state_next = ST_RUN;
        default:   state_next = ST_RUN;
      endcase
    end else if (timeout_hit) begin
      state_next = ST_RUN;
    end
  end

  // State register plus every registered output, decoded from the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_RUN;
      enable     <= ENABLE_RUN;
      field      <= FIELD_NONE;
      set_hour   <= 8'h00;
      set_minute <= 8'h00;
      set_second <= 8'h00;
      idle_cnt   <= '0;
      blink_cnt  <= '0;
      blink      <= 1'b0;
    end else begin
      state  <= state_next;
      enable <= (state_next == ST_RUN) ? ENABLE_RUN : ENABLE_SET;
      field  <= field_of(state_next);

      if (any_btn || (state_next != state) || (state_next == ST_RUN))
        idle_cnt <= '0;
      else if (idle_cnt < IW'(TIMEOUT))
        idle_cnt <= idle_cnt + IW'(1);

      if ((state == ST_RUN) && btn_mode) begin
        set_hour   <= h;
        set_minute <= m;
        set_second <= s;
      end else if (!btn_mode && (btn_up ^ btn_down)) begin
        case (state)
          ST_EDIT_H: set_hour   <= hour_step;
          ST_EDIT_M: set_minute <= minute_step;
          ST_EDIT_S: set_second <= second_step;
          default:   ;
        endcase
      end

      if (state_next == ST_RUN) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (state == ST_RUN) begin
        blink     <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a decimal reference model feeding a scoreboard.
module tb_clock_set_ctrl;

  localparam int TIMEOUT   = 4;
  localparam int BLINK_DIV = 2;

  logic       clk;
  logic       resetn;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] h;
  logic [7:0] m;
  logic [7:0] s;
  logic [3:0] enable;
  logic [7:0] set_hour;
  logic [7:0] set_minute;
  logic [7:0] set_second;
  logic [2:0] field;
  logic       blink;

  clock_set_ctrl #(
    .TIMEOUT   (TIMEOUT),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .h          (h),
    .m          (m),
    .s          (s),
    .enable     (enable),
    .set_hour   (set_hour),
    .set_minute (set_minute),
    .set_second (set_second),
    .field      (field),
    .blink      (blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] enable;
    logic [2:0] field;
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       blink;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model, kept in plain decimal integers
  int   m_state;
  int   m_hr;
  int   m_mn;
  int   m_sc;
  int   m_idle;
  int   m_bcnt;
  logic m_blink;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic modelReset();
    m_state = 0; m_hr = 0; m_mn = 0; m_sc = 0;
    m_idle = 0; m_bcnt = 0; m_blink = 1'b0;
  endtask

  task automatic pushExpected();
    exp_t e;
    e.enable = (m_state == 0) ? 4'b0001 : 4'b0100;
    case (m_state)
      1:       e.field = 3'b100;
      2:       e.field = 3'b010;
      3:       e.field = 3'b001;
      default: e.field = 3'b000;
    endcase
    e.hr    = to_bcd(m_hr);
    e.mn    = to_bcd(m_mn);
    e.sc    = to_bcd(m_sc);
    e.blink = m_blink;
    sb.push_back(e);
  endtask

  task automatic modelStep(input logic bm, input logic bu, input logic bd);
    int prev;
    int range;
    int val;
    prev = m_state;
    if (bm) begin
      if (m_state == 0) begin
        m_hr = from_bcd(h); m_mn = from_bcd(m); m_sc = from_bcd(s);
      end
      m_state = (m_state + 1) % 4;
      m_idle = 0;
    end else begin
      if (m_state != 0 && (bu ^ bd)) begin
        range = (m_state == 1) ? 24 : 60;
        val = (m_state == 1) ? m_hr : (m_state == 2) ? m_mn : m_sc;
        val = bu ? (val + 1) % range : (val + range - 1) % range;
        if (m_state == 1) m_hr = val;
        else if (m_state == 2) m_mn = val;
        else m_sc = val;
      end
      if (bu || bd) m_idle = 0;
      else if (m_state != 0) begin
        m_idle++;
        if (m_idle >= TIMEOUT) begin
          m_state = 0;
          m_idle = 0;
        end
      end
    end
    if (m_state == 0) begin
      m_blink = 1'b0; m_bcnt = 0;
    end else if (prev == 0) begin
      m_blink = 1'b1; m_bcnt = 0;
    end else begin
      m_bcnt++;
      if (m_bcnt == BLINK_DIV) begin
        m_blink = ~m_blink;
        m_bcnt = 0;
      end
    end
  endtask

  task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sb.pop_front();
      checkField({tag, ".enable"}, {4'h0, enable}, {4'h0, e.enable});
      checkField({tag, ".field"},  {5'h0, field},  {5'h0, e.field});
      checkField({tag, ".hour"},   set_hour,       e.hr);
      checkField({tag, ".minute"}, set_minute,     e.mn);
      checkField({tag, ".second"}, set_second,     e.sc);
      checkField({tag, ".blink"},  {7'h0, blink},  {7'h0, e.blink});
    end
  endtask

  // One clock of buttons: model predicts, DUT steps, outputs checked just after the edge
  task automatic applyStimulus(input string tag, input logic bm, input logic bu, input logic bd);
    btn_mode = bm; btn_up = bu; btn_down = bd;
    modelStep(bm, bu, bd);
    pushExpected();
    @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    resetn = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    h = 8'h12; m = 8'h34; s = 8'h56;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    pushExpected();
    checkOutput("reset");

    applyStimulus("run_idle", 1'b0, 1'b0, 1'b0);
    applyStimulus("run_up", 1'b0, 1'b1, 1'b0);
    applyStimulus("entry_capture", 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) applyStimulus("hour_up", 1'b0, 1'b1, 1'b0);
    applyStimulus("hour_wrap_up", 1'b0, 1'b1, 1'b0);
    applyStimulus("hour_wrap_down", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) applyStimulus("hour_down", 1'b0, 1'b0, 1'b1);
    applyStimulus("prio_mode_up", 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 25; i++) applyStimulus("min_up", 1'b0, 1'b1, 1'b0);
    applyStimulus("min_wrap_up", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("min_idle", 1'b0, 1'b0, 1'b0);
    applyStimulus("up_down_pair", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("min_idle_after_pair", 1'b0, 1'b0, 1'b0);

    applyStimulus("to_second", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) applyStimulus("sec_up", 1'b0, 1'b1, 1'b0);
    applyStimulus("sec_carry_up", 1'b0, 1'b1, 1'b0);
    applyStimulus("sec_borrow_down", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus("timeout", 1'b0, 1'b0, 1'b0);

    h = 8'h08; m = 8'h15; s = 8'h42;
    for (int k = 0; k < 4; k++) begin
      applyStimulus("cycle_mode", 1'b1, 1'b0, 1'b0);
      applyStimulus("cycle_idle", 1'b0, 1'b0, 1'b0);
      applyStimulus("cycle_idle", 1'b0, 1'b0, 1'b0);
      applyStimulus("cycle_idle", 1'b0, 1'b0, 1'b0);
    end

    applyStimulus("pre_reset_h", 1'b1, 1'b0, 1'b0);
    applyStimulus("pre_reset_up", 1'b0, 1'b1, 1'b0);
    applyStimulus("pre_reset_m", 1'b1, 1'b0, 1'b0);
    applyStimulus("pre_reset_up", 1'b0, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    modelReset();
    pushExpected();
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus("post_reset", 1'b0, 1'b0, 1'b0);
    applyStimulus("post_reset_entry", 1'b1, 1'b0, 1'b0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode/edit controller that sequences the time-of-day counter block: drives its 4-bit `enable` code and its BCD `set_hour`/`set_minute`/`set_second` load values from three debounced user buttons. It sits between the button front-end and the counter. It owns the run/set mode, per-field BCD editing with wrap-around, an idle timeout back to run mode, and field-select and blink indications for the display driver.

## Interface

Parameters:
- `TIMEOUT`, default 30: idle `clk` cycles in an edit state before forced return to RUN (≥1).
- `BLINK_DIV`, default 2: `clk` cycles per `blink` half-period (≥1).

Ports:
- `clk`  in  1  clock; one cycle is one counter tick.
- `resetn`  in  1  reset, asynchronous, active-low.
- `btn_mode`  in  1  single-cycle pulse; advance edit field.
- `btn_up`  in  1  single-cycle pulse; increment the selected field.
- `btn_down`  in  1  single-cycle pulse; decrement the selected field.
- `h`, `m`, `s`  in  8 each  current time from the counter, BCD `{tens, ones}`.
- `enable`  out  4  mode code to the counter: 4'b0001 = run, 4'b0100 = set/load.
- `set_hour`, `set_minute`, `set_second`  out  8 each  BCD load values.
- `field`  out  3  one-hot selected field: 100 = hour, 010 = minute, 001 = second, 000 = none.
- `blink`  out  1  display blink for the selected field.

## Operation

- **States:** RUN, EDIT_H, EDIT_M, EDIT_S.
- **Transitions on `btn_mode`:**
  - RUN→EDIT_H
  - EDIT_H→EDIT_M
  - EDIT_M→EDIT_S
  - EDIT_S→RUN
- **Timeout:** in any EDIT state, the idle counter reaching `TIMEOUT` moves the state to RUN.
- **Capture on entry:** on the RUN→EDIT_H edge, `set_*` <= `{h, m, s}`.
- **Edit values in RUN:** outside the entry edge, `set_*` hold their value in RUN.
- **Editing:** in EDIT_x, `btn_up`/`btn_down` change only the selected field, in BCD.
- **Field ranges and wrap:**
  - hour 00..23: 23+1 → 00, 00−1 → 23.
  - minute and second 00..59: 59+1 → 00, 00−1 → 59.
  - Ones digit: 9+1 → 0 with tens+1; 0−1 → 9 with tens−1.
- **Output decode:**
  - `enable` = 4'b0100 in EDIT states and 4'b0001 in RUN. It is never 0000.
  - `field` is decoded from the state.
- **Button priority:**
  - `btn_mode` beats `btn_up`/`btn_down`. Same cycle: the field advances and the value is unchanged.
  - `btn_up` together with `btn_down`: no change to the field value, but the pair still counts as activity.
- **Idle counter:**
  - Width `$clog2(TIMEOUT+1)`.
  - Cleared on any button pulse and on every state change.
  - Increments in EDIT states and is held at 0 in RUN.
  - Saturates at `TIMEOUT`.
- **Timeout exit:** the edited values are kept. The counter loaded them continuously while `enable` was 0100.
- **Blink:**
  - A divider counts `BLINK_DIV` cycles and toggles `blink`.
  - Forced to 0 in RUN, and the divider is cleared in RUN.
  - Restarts at 1 on entry to EDIT_H.
- **Reset mid-edit:**
  - State RUN, `set_*` = 8'h00.
  - `enable` 4'b0001, `field` 000, `blink` 0, all counters cleared.

## Timing

- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Button latency:** a button pulse sampled at edge k is reflected on the outputs after edge k.
- **Counter loading:** the counter loads `set_*` from edge k+1 onward.
- **Hold-over lag:** entering set freezes time one tick behind the live value. This is intentional and accepted.
- **Timeout timing:** the last button pulse at edge k gives RUN after edge k+`TIMEOUT`.
- **Button pulses:** pulses are one cycle wide. A held level is treated as a pulse every cycle; spacing is not checked.

## Structure

- **Package `clock_pkg`:**
  - state typedef
  - `ENABLE_RUN` = 4'b0001, `ENABLE_SET` = 4'b0100
  - `HOUR_MAX` = 8'h23, `MINSEC_MAX` = 8'h59
  - `FIELD_*` one-hot constants
- **Sub-module `bcd_field_step`:**
  - Combinational BCD ±1 with wrap, selected by a `max` input.
  - Instantiated three times, one per field.

## Test plan

- **Reset:** assert `resetn` = 0 mid-EDIT_M → `enable` = 0001, `field` = 000, `set_*` = 00, `blink` = 0, immediately and asynchronously.
- **Entry capture:** `h`/`m`/`s` = 12/34/56 and `btn_mode` → next cycle `enable` = 0100, `field` = 100, `set_*` = 12/34/56.
- **Wrap:**
  - EDIT_H at 23, `btn_up` → 00, then `btn_down` → 23.
  - EDIT_M at 59, `btn_up` → 00.
  - EDIT_S at 09, `btn_up` → 10; at 10, `btn_down` → 09.
- **Priority:** `btn_mode` with `btn_up` in EDIT_H at 05 → EDIT_M, hour stays 05. `btn_up` with `btn_down` → value unchanged, idle counter cleared.
- **Timeout:** `TIMEOUT` = 4, last pulse at cycle 10 → RUN after cycle 14, `set_*` retain the edited values, `enable` = 0001.
- **Full cycle:** `btn_mode` ×4 → field sequence 100, 010, 001, 000. `blink` toggles every `BLINK_DIV` cycles only while `field` ≠ 000.
